rr_bus_scheduler: RTL and testbench
===================================

// Module: rr_bus_scheduler
// PURPOSE
//  Request-driven round-robin scheduler for the single shared memory/peripheral bus.
//  Replaces blind time-slicing with arbitration by request. Only cores that request
//  the bus are granted it. Each grant lasts a bounded quantum, and an atomic
//  (LR/SC/AMO) lock defers handover. Sits between the cores' bus ports and the
//  grant-driven bus mux. It drives the mux select and the per-core busy stall lines.
// PARAMETERS
//  NCORES   2   number of cores; power of two, 2..8
//  GW       3   width of the grant index; must satisfy 2**GW >= NCORES
//  QUANTUM  2   OWN cycles before handover is considered (1..255)
//  GUARD    1   all-busy cycles after a grant change (0..15)
// PORTS
//  CLK            in   1       system clock
//  RST_X          in   1       synchronous reset, active low
//  w_init_done    in   1       memory init finished; scheduler frozen while 0
//  w_req          in   NCORES  core i has a pending bus operation
//  w_idle         in   NCORES  core i is at an instruction boundary (cpustate == S_ID)
//  w_lock         in   NCORES  core i is inside an atomic sequence
//  w_sys_busy     in   1       shared resources busy (dram / uart tx / data busy)
//  w_grant        out  GW      index of the bus owner; drives the bus mux select
//  w_grant_valid  out  1       1 only in OWN/DRAIN
//  w_busy         out  NCORES  per-core stall (dram_busy to core i)
//  w_handovers    out  32      count of grant changes; wraps modulo 2**32
// BEHAVIOUR
//  Reset (RST_X=0 at a CLK edge):
//   - state=IDLE, grant=0, cnt=0, handovers=0
//   - outputs: w_grant=0, w_grant_valid=0, w_busy=all ones
//  w_init_done=0: all registers hold their values. w_busy is forced to all ones.
//  States and owner busy (every non-owner bit is always 1):
//   - IDLE:  owner busy=1
//   - GUARD: owner busy=1
//   - OWN:   owner busy=w_sys_busy
//   - DRAIN: owner busy=w_sys_busy, except 1 in the handover cycle
//  Busy is combinational from the registered state and w_sys_busy.
//  pick = first i with w_req[i]=1, scanning (grant+1)..(grant+NCORES) mod NCORES.
//   The owner itself is scanned last.
//  IDLE:
//   - if any w_req bit is set: grant<=pick; go to GUARD, or to OWN if GUARD=0; cnt<=0.
//   - if pick==grant, handovers does not increment; otherwise handovers+1.
//  GUARD: counts GUARD cycles, then OWN with cnt<=0.
//  OWN:
//   - cnt increments each cycle and saturates at QUANTUM.
//   - go to DRAIN when cnt==QUANTUM-1 or w_req[grant]=0.
//  DRAIN: handover cycle = w_idle[grant] & !w_lock[grant] & !w_sys_busy. In that cycle:
//   - another requester exists: grant<=pick, handovers+1, go to GUARD (or OWN).
//   - only the owner requests: stay owner, OWN, cnt<=0, no guard, no increment.
//   - no requests: go to IDLE; grant keeps its value.
//  Latency: a request seen in IDLE gets its first non-busy cycle after 1+GUARD edges.
//  Lock: w_lock[grant]=1 blocks handover indefinitely; the quantum does not preempt.
//  w_req/w_idle/w_lock are sampled only in the decision cycle. Drops of w_req by
//   non-owners between decision cycles are ignored.
//  Mid-operation reset: immediate return to the reset values. No partial handover.
//  Counter widths: cnt is 8 bits; the guard counter is 4 bits. Compares are unsigned.
// STRUCTURE
//  define.vh: NCORES, and ARB_IDLE/ARB_GUARD/ARB_OWN/ARB_DRAIN encodings (2 bits).
//  Sub-module rr_pick: combinational round-robin next-index finder.
//   - inputs: req vector, current index
//   - outputs: pick, any
//  The top level holds the FSM, counters and the busy decode.
// TESTING
//  1. Reset, init_done=1, w_req=2'b10 -> cycle+1 grant=1, GUARD;
//     cycle+2 w_busy=2'b01, valid=1; handovers=1.
//  2. Both req=1, idle=1, sys_busy=0, QUANTUM=2, GUARD=1 -> grant alternates
//     0,1,0,... with period 4; handovers +1 per swap.
//  3. Owner 0, w_lock[0]=1 for 20 cycles while core 1 requests
//     -> grant stays 0 for 20 cycles; swap 1+GUARD cycles after lock drops.
//  4. Only core 0 requests continuously -> grant=0 forever; handovers frozen;
//     w_busy[0] low except 1 cycle per quantum.
//  5. w_sys_busy=1 in DRAIN with idle=1 -> no handover until sys_busy=0;
//     owner busy follows sys_busy.
//  6. RST_X=0 during GUARD after a swap -> next cycle grant=0, IDLE,
//     busy=all ones, handovers=0; init_done=0 freezes all state.

Source files
------------

// File: rtl/rr_bus_scheduler_pkg.sv
// Shared types and widths for the round-robin bus scheduler.
// The arbiter FSM encoding is 2 bits; counter widths are fixed by the design.
package rr_bus_scheduler_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GUARD = 2'd1,
    ARB_OWN   = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_t;

  localparam int CNT_W  = 8;
  localparam int GCNT_W = 4;
  localparam int HO_W   = 32;

  // Increment that sticks at lim (unsigned compare).
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_bus_scheduler_if.sv
// Bundle of core-side request lines and scheduler-side grant/stall lines.
// slave = scheduler view, master = core/bus side that drives requests.
interface rr_bus_scheduler_if #(
  parameter int NCORES = 2,
  parameter int GW     = 3
);
  import rr_bus_scheduler_pkg::*;

  logic              w_init_done;
  logic [NCORES-1:0] w_req;
  logic [NCORES-1:0] w_idle;
  logic [NCORES-1:0] w_lock;
  logic              w_sys_busy;
  logic [GW-1:0]     w_grant;
  logic              w_grant_valid;
  logic [NCORES-1:0] w_busy;
  logic [HO_W-1:0]   w_handovers;
  arb_state_t        w_dbg_state;

  // Handshake: w_busy[i]=0 means core i may use the bus this cycle; the
  // mux follows w_grant whenever w_grant_valid=1. Requests are level-held.
  modport master (
    output w_init_done, w_req, w_idle, w_lock, w_sys_busy,
    input  w_grant, w_grant_valid, w_busy, w_handovers, w_dbg_state
  );

  modport slave (
    input  w_init_done, w_req, w_idle, w_lock, w_sys_busy,
    output w_grant, w_grant_valid, w_busy, w_handovers, w_dbg_state
  );

endinterface

// File: rtl/rr_bus_scheduler_pick.sv
// Combinational round-robin finder: first requester after i_idx, i_idx itself last.
// NCORES is a power of two, so the wrap-around distance is a simple mask.
module rr_bus_scheduler_pick #(
  parameter int NCORES = 2,
  parameter int GW     = 3
) (
  input  logic [NCORES-1:0] i_req,
  input  logic [GW-1:0]     i_idx,
  output logic [GW-1:0]     o_pick,
  output logic              o_any
);

  logic [GW-1:0] w_dist;
  logic [GW-1:0] w_best;

  always_comb begin
    o_pick = i_idx;
    o_any  = 1'b0;
    w_best = '1;
    w_dist = '0;
    for (int i = 0; i < NCORES; i++) begin
      // Distance 0 is idx+1; idx itself lands on NCORES-1, i.e. scanned last.
      w_dist = (GW'(i) - i_idx - GW'(1)) & GW'(NCORES - 1);
      if (i_req[i] && (!o_any || (w_dist < w_best))) begin
        o_any  = 1'b1;
        w_best = w_dist;
        o_pick = GW'(i);
      end
    end
  end

endmodule

// File: rtl/rr_bus_scheduler.sv
// Request-driven round-robin owner of the shared bus: FSM, quantum/guard
// counters, handover counter and the per-core busy (stall) decode.
module rr_bus_scheduler
  import rr_bus_scheduler_pkg::*;
#(
  parameter int NCORES  = 2,
  parameter int GW      = 3,
  parameter int QUANTUM = 2,
  parameter int GUARD   = 1
) (
  input  logic              CLK,
  input  logic              RST_X,
  rr_bus_scheduler_if.slave bus
);

  localparam arb_state_t ST_AFTER_PICK = (GUARD == 0) ? ARB_OWN : ARB_GUARD;

  arb_state_t          r_state, w_state_nxt;
  logic [GW-1:0]       r_grant, w_grant_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [GCNT_W-1:0]   r_gcnt, w_gcnt_nxt;
  logic [HO_W-1:0]     r_handovers, w_handovers_nxt;

  logic [NCORES-1:0]   w_own_oh;
  logic [GW-1:0]       w_pick;
  logic                w_any;
  logic                w_own_req, w_own_idle, w_own_lock, w_others;
  logic                w_handover_cyc;
  logic                w_owner_busy;

  rr_bus_scheduler_pick #(.NCORES(NCORES), .GW(GW)) u_pick (
    .i_req  (bus.w_req),
    .i_idx  (r_grant),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  always_comb begin
    w_own_oh = '0;
    for (int i = 0; i < NCORES; i++) w_own_oh[i] = (r_grant == GW'(i));
  end

  assign w_own_req      = |(bus.w_req  & w_own_oh);
  assign w_own_idle     = |(bus.w_idle & w_own_oh);
  assign w_own_lock     = |(bus.w_lock & w_own_oh);
  assign w_others       = |(bus.w_req  & ~w_own_oh);
  assign w_handover_cyc = w_own_idle & ~w_own_lock & ~bus.w_sys_busy;

  // Whole register set freezes until memory init completes.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_state     <= ARB_IDLE;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_gcnt      <= '0;
      r_handovers <= '0;
    end else if (bus.w_init_done) begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gcnt      <= w_gcnt_nxt;
      r_handovers <= w_handovers_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_cnt_nxt       = r_cnt;
    w_gcnt_nxt      = r_gcnt;
    w_handovers_nxt = r_handovers;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_AFTER_PICK;
          w_cnt_nxt   = '0;
          w_gcnt_nxt  = '0;
          if (w_pick != r_grant) w_handovers_nxt = r_handovers + 1'b1;
        end
      end
      ARB_GUARD: begin
        if (r_gcnt >= GCNT_W'(GUARD - 1)) begin
          w_state_nxt = ARB_OWN;
          w_cnt_nxt   = '0;
          w_gcnt_nxt  = '0;
        end else begin
          w_gcnt_nxt = r_gcnt + 1'b1;
        end
      end
      ARB_OWN: begin
        w_cnt_nxt = sat_inc(r_cnt, CNT_W'(QUANTUM));
        if ((r_cnt == CNT_W'(QUANTUM - 1)) || !w_own_req) w_state_nxt = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        // Another requester exists only if pick differs from the owner.
        if (w_handover_cyc) begin
          if (w_others) begin
            w_grant_nxt     = w_pick;
            w_handovers_nxt = r_handovers + 1'b1;
            w_state_nxt     = ST_AFTER_PICK;
            w_cnt_nxt       = '0;
            w_gcnt_nxt      = '0;
          end else if (w_own_req) begin
            w_state_nxt = ARB_OWN;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    case (r_state)
      ARB_OWN:   w_owner_busy = bus.w_sys_busy;
      ARB_DRAIN: w_owner_busy = bus.w_sys_busy | w_handover_cyc;
      default:   w_owner_busy = 1'b1;
    endcase
    bus.w_busy = '1;
    if (bus.w_init_done) bus.w_busy = ~w_own_oh | {NCORES{w_owner_busy}};
    bus.w_grant_valid = (r_state == ARB_OWN) || (r_state == ARB_DRAIN);
  end

  assign bus.w_grant     = r_grant;
  assign bus.w_handovers = r_handovers;
  assign bus.w_dbg_state = r_state;

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Directed bench for rr_bus_scheduler (NCORES=2, QUANTUM=2, GUARD=1): expected
// outputs are queued per step and popped/compared at the following negedge.
module tb_rr_bus_scheduler;
  import rr_bus_scheduler_pkg::*;

  localparam int NCORES  = 2;
  localparam int GW      = 3;
  localparam int QUANTUM = 2;
  localparam int GUARD   = 1;
  localparam int W       = 2 + GW + 1 + NCORES + 32;

  // clock / reset
  logic CLK   = 1'b0;
  logic RST_X = 1'b0;
  always #5 CLK = ~CLK;

  rr_bus_scheduler_if #(.NCORES(NCORES), .GW(GW)) bus ();

  rr_bus_scheduler #(
    .NCORES(NCORES), .GW(GW), .QUANTUM(QUANTUM), .GUARD(GUARD)
  ) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_assert = 0;
  int           n_fail   = 0;

  function automatic logic [NCORES-1:0] own_busy(input int o);
    return (o == 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic cmp(input string t, input string f, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", t, f, obs, exp);
    end
  endtask

  task automatic expect_out(input string t, input arb_state_t st, input int g,
                            input logic v, input logic [NCORES-1:0] b,
                            input logic [31:0] ho);
    exp_q.push_back({st, GW'(g), v, b, ho});
    tag_q.push_back(t);
  endtask

  task automatic check_out();
    logic [W-1:0] e;
    string        t;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "state",     32'(bus.w_dbg_state),   32'(e[W-1 -: 2]));
      cmp(t, "grant",     32'(bus.w_grant),       32'(e[W-3 -: GW]));
      cmp(t, "valid",     32'(bus.w_grant_valid), 32'(e[32+NCORES]));
      cmp(t, "busy",      32'(bus.w_busy),        32'(e[32 +: NCORES]));
      cmp(t, "handovers", bus.w_handovers,        e[31:0]);
    end
  endtask

  // driver tasks: step = one clock edge then check; now_chk = combinational check
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic step(input string t, input arb_state_t st, input int g,
                      input logic v, input logic [NCORES-1:0] b, input logic [31:0] ho);
    expect_out(t, st, g, v, b, ho);
    tick();
    check_out();
  endtask

  task automatic now_chk(input string t, input arb_state_t st, input int g,
                         input logic v, input logic [NCORES-1:0] b, input logic [31:0] ho);
    expect_out(t, st, g, v, b, ho);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o;
    bus.w_init_done = 1'b0;
    bus.w_req       = 2'b00;
    bus.w_idle      = 2'b00;
    bus.w_lock      = 2'b00;
    bus.w_sys_busy  = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    now_chk("reset", ARB_IDLE, 0, 1'b0, 2'b11, 32'd0);

    // first grant: core 1 alone, GUARD then OWN
    RST_X = 1'b1;
    bus.w_init_done = 1'b1;
    bus.w_req  = 2'b10;
    bus.w_idle = 2'b11;
    step("t1_guard", ARB_GUARD, 1, 1'b0, 2'b11, 32'd1);
    step("t1_own0",  ARB_OWN,   1, 1'b1, 2'b01, 32'd1);
    step("t1_own1",  ARB_OWN,   1, 1'b1, 2'b01, 32'd1);
    step("t1_drain", ARB_DRAIN, 1, 1'b1, 2'b11, 32'd1);
    bus.w_req = 2'b00;
    step("t1_idle",  ARB_IDLE,  1, 1'b0, 2'b11, 32'd1);

    // both request: alternate owners every 4 cycles
    bus.w_req = 2'b11;
    o = 0;
    for (int s = 0; s < 4; s++) begin
      step("alt_guard", ARB_GUARD, o, 1'b0, 2'b11,       32'(2 + s));
      step("alt_own0",  ARB_OWN,   o, 1'b1, own_busy(o), 32'(2 + s));
      step("alt_own1",  ARB_OWN,   o, 1'b1, own_busy(o), 32'(2 + s));
      step("alt_drain", ARB_DRAIN, o, 1'b1, 2'b11,       32'(2 + s));
      o = 1 - o;
    end

    // atomic lock on core 0 holds DRAIN for 20 cycles
    bus.w_lock = 2'b01;
    step("lk_guard", ARB_GUARD, 0, 1'b0, 2'b11, 32'd6);
    step("lk_own0",  ARB_OWN,   0, 1'b1, 2'b10, 32'd6);
    step("lk_own1",  ARB_OWN,   0, 1'b1, 2'b10, 32'd6);
    for (int s = 0; s < 20; s++) step("lk_hold", ARB_DRAIN, 0, 1'b1, 2'b10, 32'd6);
    bus.w_lock = 2'b00;
    now_chk("lk_release", ARB_DRAIN, 0, 1'b1, 2'b11, 32'd6);
    step("lk_guard1", ARB_GUARD, 1, 1'b0, 2'b11, 32'd7);
    step("lk_own1_0", ARB_OWN,   1, 1'b1, 2'b01, 32'd7);
    step("lk_own1_1", ARB_OWN,   1, 1'b1, 2'b01, 32'd7);

    // shared resources busy: owner busy follows sys_busy, no handover
    bus.w_sys_busy = 1'b1;
    now_chk("sb_own",   ARB_OWN,   1, 1'b1, 2'b11, 32'd7);
    step("sb_drain0",   ARB_DRAIN, 1, 1'b1, 2'b11, 32'd7);
    step("sb_drain1",   ARB_DRAIN, 1, 1'b1, 2'b11, 32'd7);
    step("sb_drain2",   ARB_DRAIN, 1, 1'b1, 2'b11, 32'd7);
    bus.w_idle     = 2'b00;
    bus.w_sys_busy = 1'b0;
    now_chk("sb_notidle", ARB_DRAIN, 1, 1'b1, 2'b01, 32'd7);
    step("sb_notidle1",   ARB_DRAIN, 1, 1'b1, 2'b01, 32'd7);
    bus.w_idle = 2'b11;
    bus.w_req  = 2'b01;
    now_chk("sb_handover", ARB_DRAIN, 1, 1'b1, 2'b11, 32'd7);
    step("sb_guard0",      ARB_GUARD, 0, 1'b0, 2'b11, 32'd8);

    // only core 0 requests: re-grants itself, handovers frozen
    for (int s = 0; s < 3; s++) begin
      step("solo_own0",  ARB_OWN,   0, 1'b1, 2'b10, 32'd8);
      step("solo_own1",  ARB_OWN,   0, 1'b1, 2'b10, 32'd8);
      step("solo_drain", ARB_DRAIN, 0, 1'b1, 2'b11, 32'd8);
    end

    // freeze during GUARD, then reset mid-guard
    bus.w_req = 2'b11;
    step("rs_guard", ARB_GUARD, 1, 1'b0, 2'b11, 32'd9);
    bus.w_init_done = 1'b0;
    for (int s = 0; s < 3; s++) step("rs_frozen", ARB_GUARD, 1, 1'b0, 2'b11, 32'd9);
    bus.w_init_done = 1'b1;
    RST_X = 1'b0;
    step("rs_reset", ARB_IDLE, 0, 1'b0, 2'b11, 32'd0);
    RST_X = 1'b1;
    bus.w_init_done = 1'b0;
    bus.w_req = 2'b10;
    step("rs_idle_frozen0", ARB_IDLE, 0, 1'b0, 2'b11, 32'd0);
    step("rs_idle_frozen1", ARB_IDLE, 0, 1'b0, 2'b11, 32'd0);
    bus.w_init_done = 1'b1;
    step("rs_guard1", ARB_GUARD, 1, 1'b0, 2'b11, 32'd1);
    step("rs_own1",   ARB_OWN,   1, 1'b1, 2'b01, 32'd1);

    // owner drops its request early: DRAIN before the quantum, then IDLE
    bus.w_req = 2'b00;
    step("drop_drain", ARB_DRAIN, 1, 1'b1, 2'b11, 32'd1);
    step("drop_idle",  ARB_IDLE,  1, 1'b0, 2'b11, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
